// File: rtl/axi_copy_master.sv
// axi_copy_master: copies len words from src_addr to dst_addr, one outstanding AXI4-lite transaction at a time.
// Define AXI_COPY_TIMEOUT_EN to abort any handshake stalled for 255 cycles, raising err.
module axi_copy_master (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [9:0]  len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [9:0]  words_done,
    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata,
    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready
);
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, DONE} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_src, r_dst, r_hold;
    logic [9:0]  r_len, r_words;
    logic        r_aw_done, r_w_done;
    logic        w_accept, w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_wr_ok, w_last, w_to;

    assign w_accept = (r_state == IDLE) && start;
    assign w_ar_hs  = mem_axi_arvalid && mem_axi_arready;
    assign w_r_hs   = mem_axi_rvalid && mem_axi_rready;
    assign w_aw_hs  = mem_axi_awvalid && mem_axi_awready;
    assign w_w_hs   = mem_axi_wvalid && mem_axi_wready;
    assign w_b_hs   = mem_axi_bvalid && mem_axi_bready;
    assign w_wr_ok  = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
    assign w_last   = ({1'b0, r_words} + 11'd1) == {1'b0, r_len};

`ifdef AXI_COPY_TIMEOUT_EN
    logic [7:0] r_wait;
    logic       r_err;
    logic       w_waiting;

    assign w_waiting = (r_state inside {RADDR, RDATA, WRITE, WRESP}) &&
                       !(w_ar_hs || w_r_hs || w_aw_hs || w_w_hs || w_b_hs);
    assign w_to      = (r_wait == 8'hFF);
    assign err       = r_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wait <= 8'd0;
            r_err  <= 1'b0;
        end else begin
            r_wait <= (w_waiting && !w_to) ? r_wait + 8'd1 : 8'd0;
            r_err  <= w_accept ? 1'b0 : (r_err || w_to);
        end
    end
`else
    assign w_to = 1'b0;
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !start ? IDLE : (len == 10'd0) ? DONE : RADDR;
            RADDR:   w_next = w_to ? DONE : w_ar_hs ? RDATA : RADDR;
            RDATA:   w_next = w_to ? DONE : w_r_hs ? WRITE : RDATA;
            WRITE:   w_next = w_to ? DONE : w_wr_ok ? WRESP : WRITE;
            WRESP:   w_next = w_to ? DONE : !w_b_hs ? WRESP : w_last ? DONE : RADDR;
            default: w_next = IDLE;
        endcase
    end

    // Valids come straight from state so an asynchronous reset drops them in the same cycle.
    always_comb begin
        busy            = (r_state != IDLE);
        done            = (r_state == DONE);
        words_done      = r_words;
        mem_axi_arvalid = (r_state == RADDR) && !w_to;
        mem_axi_rready  = (r_state == RDATA) && !w_to;
        mem_axi_awvalid = (r_state == WRITE) && !r_aw_done && !w_to;
        mem_axi_wvalid  = (r_state == WRITE) && !r_w_done && !w_to;
        mem_axi_bready  = (r_state == WRESP) && !w_to;
        mem_axi_araddr  = r_src + {20'd0, r_words, 2'b00};
        mem_axi_awaddr  = r_dst + {20'd0, r_words, 2'b00};
        mem_axi_wdata   = r_hold;
        mem_axi_wstrb   = (r_state == WRITE) ? 4'hF : 4'h0;
        mem_axi_arprot  = 3'b000;
        mem_axi_awprot  = 3'b000;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_src     <= 32'd0;
            r_dst     <= 32'd0;
            r_len     <= 10'd0;
            r_words   <= 10'd0;
            r_hold    <= 32'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_src <= src_addr;
                r_dst <= dst_addr;
                r_len <= len;
            end
            if (w_r_hs)
                r_hold <= mem_axi_rdata;
            r_words   <= w_accept ? 10'd0 : r_words + {9'd0, w_b_hs};
            r_aw_done <= (w_next == WRITE) && (r_aw_done || w_aw_hs);
            r_w_done  <= (w_next == WRITE) && (r_w_done || w_w_hs);
        end
    end
endmodule

// File: tb/tb_axi_copy_master.sv
// tb_axi_copy_master: randomized bench; a memory responder logs AXI traffic which is compared with a word-level copy model.
`timescale 1ns/1ps
module tb_axi_copy_master;
    logic        clk = 1'b0, resetn = 1'b0, start = 1'b0;
    logic [31:0] src_addr = 32'd0, dst_addr = 32'd0;
    logic [9:0]  len = 10'd0;
    logic        busy, done, err;
    logic [9:0]  words_done;
    logic        mem_axi_arvalid, mem_axi_rready, mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready;
    logic [31:0] mem_axi_araddr, mem_axi_awaddr, mem_axi_wdata;
    logic [2:0]  mem_axi_arprot, mem_axi_awprot;
    logic [3:0]  mem_axi_wstrb;
    logic        mem_axi_arready = 1'b0, mem_axi_rvalid = 1'b0, mem_axi_awready = 1'b0;
    logic        mem_axi_wready = 1'b0, mem_axi_bvalid = 1'b0;
    logic [31:0] mem_axi_rdata = 32'd0;

    axi_copy_master dut (
        .clk(clk), .resetn(resetn), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .err(err), .words_done(words_done),
        .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
        .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
        .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready), .mem_axi_rdata(mem_axi_rdata),
        .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
        .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
        .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
        .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
        .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    logic [31:0] rq[$];
    wr_t         wq[$];
    int          n_checks = 0, n_errors = 0;
    int          mode = 1, done_cnt = 0, b_cnt = 0, req_cnt = 0, aw_cnt = 0;
    int          done_base, b_base, req_base, rq_base, wq_base, cyc;
    logic        rd_pend = 1'b0, b_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
    logic        ar_wait = 1'b0, aw_wait = 1'b0, w_wait = 1'b0, ar_hs = 1'b0, aw_hs = 1'b0, w_hs = 1'b0;
    logic [31:0] rd_word = 32'd0, aw_a = 32'd0, w_d = 32'd0, ar_prev = 32'd0, aw_prev = 32'd0, w_prev = 32'd0;
    logic [3:0]  w_s = 4'd0;

    // Memory contents seen by the responder: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Responder modes: 0 random waits, 1 zero-wait, 2 wready 3 cycles ahead of awready, 3 arready stuck low.
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mem_axi_arready = 1'b0; mem_axi_rvalid = 1'b0; mem_axi_awready = 1'b0;
                mem_axi_wready = 1'b0; mem_axi_bvalid = 1'b0;
                rd_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0;
                ar_wait = 1'b0; aw_wait = 1'b0; w_wait = 1'b0; ar_hs = 1'b0; aw_hs = 1'b0; w_hs = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (mem_axi_arvalid || mem_axi_awvalid || mem_axi_wvalid) req_cnt++;
                if (mode != 3) begin
                    if (ar_wait) begin
                        chk("ar_hold", 32'(mem_axi_arvalid), 32'd1);
                        chk("araddr_hold", mem_axi_araddr, ar_prev);
                    end
                    if (aw_wait) begin
                        chk("aw_hold", 32'(mem_axi_awvalid), 32'd1);
                        chk("awaddr_hold", mem_axi_awaddr, aw_prev);
                    end
                    if (w_wait) begin
                        chk("w_hold", 32'(mem_axi_wvalid), 32'd1);
                        chk("wdata_hold", mem_axi_wdata, w_prev);
                    end
                end
                if (ar_hs) chk("ar_drop", 32'(mem_axi_arvalid), 32'd0);
                if (aw_hs) chk("aw_drop", 32'(mem_axi_awvalid), 32'd0);
                if (w_hs)  chk("w_drop", 32'(mem_axi_wvalid), 32'd0);
                mem_axi_arready = mem_axi_arvalid && mode != 3 && (mode != 0 || $urandom_range(0, 1) == 1);
                mem_axi_rvalid  = rd_pend && (mode != 0 || $urandom_range(0, 1) == 1);
                mem_axi_rdata   = mem_axi_rvalid ? rd_word : $urandom;
                mem_axi_awready = mem_axi_awvalid && (mode == 2 ? aw_cnt >= 3 : (mode != 0 || $urandom_range(0, 1) == 1));
                mem_axi_wready  = mem_axi_wvalid && (mode != 0 || $urandom_range(0, 1) == 1);
                mem_axi_bvalid  = b_pend && (mode != 0 || $urandom_range(0, 1) == 1);
                ar_hs   = mem_axi_arvalid && mem_axi_arready;
                aw_hs   = mem_axi_awvalid && mem_axi_awready;
                w_hs    = mem_axi_wvalid && mem_axi_wready;
                ar_wait = mem_axi_arvalid && !mem_axi_arready;
                aw_wait = mem_axi_awvalid && !mem_axi_awready;
                w_wait  = mem_axi_wvalid && !mem_axi_wready;
                ar_prev = mem_axi_araddr;
                aw_prev = mem_axi_awaddr;
                w_prev  = mem_axi_wdata;
                if (ar_hs) begin
                    rq.push_back(mem_axi_araddr);
                    chk("arprot", 32'(mem_axi_arprot), 32'd0);
                    rd_word = mem_word(mem_axi_araddr);
                    rd_pend = 1'b1;
                end
                if (mem_axi_rvalid && mem_axi_rready) rd_pend = 1'b0;
                if (aw_hs) begin
                    aw_a = mem_axi_awaddr;
                    aw_got = 1'b1;
                    chk("awprot", 32'(mem_axi_awprot), 32'd0);
                end
                if (w_hs) begin
                    w_d = mem_axi_wdata;
                    w_s = mem_axi_wstrb;
                    w_got = 1'b1;
                end
                if (mem_axi_bvalid && mem_axi_bready) begin
                    b_pend = 1'b0;
                    b_cnt++;
                end
                if (aw_got && w_got) begin
                    wq.push_back('{a: aw_a, d: w_d, s: w_s});
                    aw_got = 1'b0;
                    w_got = 1'b0;
                    b_pend = 1'b1;
                end
                aw_cnt = aw_hs ? 0 : (mem_axi_awvalid ? aw_cnt + 1 : 0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [9:0] n, input int m);
        mode = m;
        done_base = done_cnt; b_base = b_cnt; req_base = req_cnt;
        rq_base = rq.size(); wq_base = wq.size();
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_1cyc", 32'(busy), 32'd1);
        src_addr = $urandom; dst_addr = $urandom; len = 10'($urandom);
        cyc = 0;
    endtask

    task automatic finish(input logic [31:0] s, input logic [31:0] d, input int n, input logic e, input int limit);
        while (!done && cyc < limit) begin
            start = (cyc == 2);
            step();
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        step();
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        chk("words_done", 32'(words_done), n);
        chk("err", 32'(err), 32'(e));
        chk("done_cnt", done_cnt - done_base, 32'd1);
        chk("b_phases", b_cnt - b_base, n);
        chk("reads", rq.size() - rq_base, n);
        chk("writes", wq.size() - wq_base, n);
        for (int i = 0; i < n && rq_base + i < rq.size(); i++)
            chk("raddr", rq[rq_base + i], s + 32'(4 * i));
        for (int i = 0; i < n && wq_base + i < wq.size(); i++) begin
            chk("waddr", wq[wq_base + i].a, d + 32'(4 * i));
            chk("wdata", wq[wq_base + i].d, mem_word(s + 32'(4 * i)));
            chk("wstrb", 32'(wq[wq_base + i].s), 32'hF);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #2;
        chk("rst_valids", 32'({mem_axi_arvalid, mem_axi_rready, mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready}), 32'd0);
        chk("rst_status", 32'({busy, done, err, words_done}), 32'd0);
        chk("rst_araddr", mem_axi_araddr, 32'd0);
        chk("rst_awaddr", mem_axi_awaddr, 32'd0);
        chk("rst_wdata", mem_axi_wdata, 32'd0);
        chk("rst_wstrb", 32'(mem_axi_wstrb), 32'd0);
        resetn = 1'b1;
        step();

        kick(32'h3000_0000, 32'h3400_0000, 10'd3, 1);
        finish(32'h3000_0000, 32'h3400_0000, 3, 1'b0, 100);
        chk("latency", 32'(cyc <= 18), 32'd1);

        kick(32'h1000_0000, 32'h2000_0000, 10'd0, 1);
        finish(32'h1000_0000, 32'h2000_0000, 0, 1'b0, 10);
        chk("len0_lat", cyc, 32'd0);
        chk("len0_noaxi", req_cnt - req_base, 32'd0);

        kick(32'h0000_1000, 32'h0000_8000, 10'd4, 2);
        finish(32'h0000_1000, 32'h0000_8000, 4, 1'b0, 200);

        kick(32'h4000_0000, 32'hFFFF_FFFC, 10'd2, 1);
        finish(32'h4000_0000, 32'hFFFF_FFFC, 2, 1'b0, 100);
        if (wq.size() > wq_base + 1) chk("wrap_awaddr", wq[wq_base + 1].a, 32'd0);

        kick(32'h5000_0000, 32'h6000_0000, 10'd5, 1);
        while (!(words_done == 10'd1 && (mem_axi_awvalid || mem_axi_wvalid)) && cyc < 50) begin
            step();
            cyc++;
        end
        chk("reach_write2", 32'(mem_axi_awvalid || mem_axi_wvalid), 32'd1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_valids", 32'({mem_axi_arvalid, mem_axi_rready, mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready}), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_words", 32'(words_done), 32'd0);
        repeat (2) step();
        resetn = 1'b1;
        repeat (4) begin
            step();
            chk("no_resume", 32'({mem_axi_arvalid, busy}), 32'd0);
        end
        kick(32'h5000_0000, 32'h6000_0000, 10'd5, 1);
        finish(32'h5000_0000, 32'h6000_0000, 5, 1'b0, 100);

        for (int k = 0; k < 8; k++) begin
            logic [31:0] s, d;
            int          n;
            s = $urandom & 32'hFFFF_FFFC;
            d = $urandom & 32'hFFFF_FFFC;
            n = $urandom_range(1, 12);
            kick(s, d, 10'(n), (k % 3 == 2) ? 2 : 0);
            finish(s, d, n, 1'b0, 3000);
        end

`ifdef AXI_COPY_TIMEOUT_EN
        kick(32'h7000_0000, 32'h7100_0000, 10'd4, 3);
        finish(32'h7000_0000, 32'h7100_0000, 0, 1'b1, 600);
        chk("to_wait", 32'(cyc >= 255), 32'd1);
        kick(32'h7000_0000, 32'h7100_0000, 10'd2, 1);
        finish(32'h7000_0000, 32'h7100_0000, 2, 1'b0, 100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axi_copy_master.md
AXI_COPY_MASTER -- requirements
Module: axi_copy_master

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have: resetn  in  1  asynchronous active-low reset.
REQ-003 SHALL have: start  in  1  one-cycle request, sampled only in IDLE.
REQ-004 SHALL have: src_addr  in  32  word-aligned read base; dst_addr  in  32  word-aligned write base; len  in  10  word count, 0..1023.
REQ-005 SHALL have: busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
REQ-006 SHALL have: done  out  1  one-cycle completion pulse; err  out  1  sticky abort flag; words_done  out  10  words written in the current or last job.
REQ-007 SHALL have these AXI4-lite initiator ports, one outstanding transaction at a time:
- mem_axi_arvalid  out  1;  mem_axi_arready  in  1;  mem_axi_araddr  out  32;  mem_axi_arprot  out  3.
- mem_axi_rvalid  in  1;  mem_axi_rready  out  1;  mem_axi_rdata  in  32.
- mem_axi_awvalid  out  1;  mem_axi_awready  in  1;  mem_axi_awaddr  out  32;  mem_axi_awprot  out  3.
- mem_axi_wvalid  out  1;  mem_axi_wready  in  1;  mem_axi_wdata  out  32;  mem_axi_wstrb  out  4.
- mem_axi_bvalid  in  1;  mem_axi_bready  out  1.

Function
REQ-008 SHALL implement a state machine with states IDLE, RADDR, RDATA, WRITE, WRESP, DONE.
REQ-009 IDLE: start=1 with len!=0 SHALL latch src, dst and len, clear words_done and err, and go to RADDR. start=1 with len==0 SHALL go to DONE and issue no AXI traffic.
REQ-010 RADDR: SHALL drive arvalid=1 with araddr=src+4*words_done. On arvalid&&arready the state SHALL go to RDATA and arvalid SHALL drop on the next cycle.
REQ-011 RDATA: SHALL drive rready=1. On rvalid the block SHALL latch rdata into a 32-bit holding register and go to WRITE.
REQ-012 WRITE: SHALL assert awvalid and wvalid together, with awaddr=dst+4*words_done, wdata=holding register and wstrb=4'b1111.
REQ-013 In WRITE, each of awvalid and wvalid SHALL drop independently after its own handshake. The AW and W handshakes may occur in either order or in the same cycle. The state SHALL go to WRESP once both have completed.
REQ-014 WRESP: SHALL drive bready=1. On bvalid the block SHALL increment words_done; if words_done+1==len it SHALL go to DONE, otherwise to RADDR.
REQ-015 DONE: SHALL pulse done=1 for exactly one cycle, then return to IDLE.
REQ-016 Once asserted, a valid SHALL be held, with payload stable, until its handshake completes.
REQ-017 Address arithmetic SHALL be 32-bit modulo 2^32; 0xFFFFFFFC+4 SHALL wrap to 0x00000000.
REQ-018 arprot and awprot SHALL be 3'b000 (data access).
REQ-019 start while busy SHALL be ignored. Changes to src_addr, dst_addr or len during a job SHALL have no effect on that job.
REQ-020 Latency with a zero-wait responder SHALL be at most 6 cycles per word, and exactly 1 cycle from start to busy.

Reset
REQ-021 resetn low SHALL immediately force state IDLE, all valid/ready outputs 0, busy 0, done 0, err 0 and words_done 0, including in the middle of a transaction.
REQ-022 araddr, awaddr and wdata SHALL reset to 0 and wstrb SHALL reset to 4'b0000.
REQ-023 After resetn rises, the first action SHALL be a new start; an interrupted transfer SHALL NOT be resumed.

Configuration
REQ-024 With macro AXI_COPY_TIMEOUT_EN defined, an 8-bit counter SHALL count cycles spent waiting in RADDR, RDATA, WRITE or WRESP. The counter SHALL reset on every handshake.
REQ-025 With AXI_COPY_TIMEOUT_EN defined, a count reaching 255 SHALL set err=1, drop all valid/ready outputs and go to DONE.
REQ-026 Without AXI_COPY_TIMEOUT_EN, err SHALL be tied to 0, no counter SHALL exist, and waits SHALL be unbounded.

Verification
REQ-027 Copy: src=0x30000000, dst=0x34000000, len=3, zero-wait responder -> reads from 0x30000000/04/08, matching writes to 0x34000000/04/08 with wstrb=F, one done pulse, words_done=3.
REQ-028 len=0 start -> done one cycle after IDLE exit, no arvalid/awvalid ever asserted, words_done=0.
REQ-029 Responder gives wready 3 cycles before awready -> wvalid drops after its handshake, awvalid holds until its handshake, exactly one bready phase per word.
REQ-030 resetn pulled low while in WRITE on word 2 of len=5 -> all valids 0 the same cycle, busy=0; a new start afterwards restarts from word 0.
REQ-031 dst=0xFFFFFFFC, len=2 -> second awaddr=0x00000000.
REQ-032 With AXI_COPY_TIMEOUT_EN defined, arready held 0 -> after 255 wait cycles err=1, one done pulse, busy=0, words_done=0.
